contador_paquetes_param: RTL and testbench

- Parametrised successor to the fixed 3-bit word counter used in packet assembly.
- Counts accepted words inside a packet and drives `sel`, the register-select index, for the packet register bank.
- Signals packet completion through a level/ack handshake or a single-cycle pulse.
- Keeps a running count of completed packets, supports abort, and offers a one-shot or auto-restart mode.

---
 rtl/contador_paquetes_param.sv | 109 ++++++++++
 tb/tb_contador_paquetes_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/contador_paquetes_param.sv
// contador_paquetes_param: word counter and register-select for packet
// assembly, with completion handshake, abort and optional auto-restart.
module contador_paquetes_param #(
  parameter int SEL_W        = 2,
  parameter int N_WORDS      = 4,
  parameter int AUTO_RESTART = 0,
  parameter int PKT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ena,
  input  logic             abort,
  input  logic             ack,
  output logic [SEL_W-1:0] sel,
  output logic             ocupado,
  output logic             listo,
  output logic             listo_pulse,
  output logic [PKT_W-1:0] paquetes
);

  if (SEL_W < 1 || N_WORDS < 1 || N_WORDS > (1 << SEL_W)) begin : g_bad_param
    $error("contador_paquetes_param: illegal SEL_W/N_WORDS");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CUENTA = 2'd1,
    LISTO  = 2'd2
  } estado_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_WORDS - 1);

  estado_t          state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic             pulse_q, pulse_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;

  // next-state, word index, packet count and completion strobe
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pkt_d   = pkt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CUENTA;
          sel_d   = '0;
        end
      end
      CUENTA: begin
        if (abort) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (ena) begin
          if (sel_q == LAST) begin
            sel_d   = '0;
            pkt_d   = pkt_q + 1'b1;
            pulse_d = 1'b1;
            if (AUTO_RESTART == 0) state_d = LISTO;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      LISTO: begin
        if (ack) begin
          state_d = start ? CUENTA : IDLE;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    ocupado_d = (state_d == CUENTA);
    listo_d   = (state_d == LISTO);
  end

  // state and registered outputs; rst overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pkt_q     <= '0;
      pulse_q   <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pkt_q     <= pkt_d;
      pulse_q   <= pulse_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  assign sel         = sel_q;
  assign ocupado     = ocupado_q;
  assign listo       = listo_q;
  assign listo_pulse = pulse_q;
  assign paquetes    = pkt_q;

endmodule

// File: tb/tb_contador_paquetes_param.sv
// tb_contador_paquetes_param: three configurations driven cycle by cycle,
// expected outputs queued from a behavioural model and compared after each edge.
module tb_contador_paquetes_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, ena, abort, ack;
  logic [1:0] sel0, sel1, sel2;
  logic [2:0] oc, li, pu;
  logic [7:0] pk0, pk1;
  logic [1:0] pk2;

  contador_paquetes_param u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .ena(ena[0]),
    .abort(abort[0]), .ack(ack[0]), .sel(sel0), .ocupado(oc[0]),
    .listo(li[0]), .listo_pulse(pu[0]), .paquetes(pk0)
  );

  contador_paquetes_param #(
    .SEL_W(2), .N_WORDS(3), .AUTO_RESTART(1), .PKT_W(8)
  ) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .ena(ena[1]),
    .abort(abort[1]), .ack(ack[1]), .sel(sel1), .ocupado(oc[1]),
    .listo(li[1]), .listo_pulse(pu[1]), .paquetes(pk1)
  );

  contador_paquetes_param #(
    .SEL_W(2), .N_WORDS(1), .AUTO_RESTART(0), .PKT_W(2)
  ) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .ena(ena[2]),
    .abort(abort[2]), .ack(ack[2]), .sel(sel2), .ocupado(oc[2]),
    .listo(li[2]), .listo_pulse(pu[2]), .paquetes(pk2)
  );

  typedef struct {
    int k;
    int sel;
    int oc;
    int li;
    int pu;
    int pk;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int nw [3] = '{4, 3, 1};
  int au [3] = '{0, 1, 0};
  int pm [3] = '{256, 256, 4};

  // model state: 0 idle, 1 counting, 2 complete
  int m_st  [3];
  int m_sel [3];
  int m_pk  [3];
  int m_pu  [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input int k);
    m_pu[k] = 0;
    if (rst[k]) begin
      m_st[k] = 0; m_sel[k] = 0; m_pk[k] = 0;
    end else if (m_st[k] == 0) begin
      if (start[k]) begin m_st[k] = 1; m_sel[k] = 0; end
    end else if (m_st[k] == 1) begin
      if (abort[k]) begin
        m_st[k] = 0; m_sel[k] = 0;
      end else if (ena[k]) begin
        if (m_sel[k] == nw[k] - 1) begin
          m_sel[k] = 0;
          m_pk[k]  = (m_pk[k] + 1) % pm[k];
          m_pu[k]  = 1;
          if (au[k] == 0) m_st[k] = 2;
        end else begin
          m_sel[k]++;
        end
      end
    end else begin
      if (ack[k]) begin m_st[k] = start[k] ? 1 : 0; m_sel[k] = 0; end
    end
    q.push_back('{k, m_sel[k], int'(m_st[k] == 1), int'(m_st[k] == 2),
                  m_pu[k], m_pk[k]});
  endtask

  function automatic int act_sel(input int k);
    return (k == 0) ? int'(sel0) : (k == 1) ? int'(sel1) : int'(sel2);
  endfunction

  function automatic int act_pk(input int k);
    return (k == 0) ? int'(pk0) : (k == 1) ? int'(pk1) : int'(pk2);
  endfunction

  // one clock: queue expectations, advance, then drain and compare
  task automatic tick();
    exp_t e;
    for (int k = 0; k < 3; k++) model(k);
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("d%0d_sel", e.k), act_sel(e.k), e.sel);
      check($sformatf("d%0d_ocupado", e.k), int'(oc[e.k]), e.oc);
      check($sformatf("d%0d_listo", e.k), int'(li[e.k]), e.li);
      check($sformatf("d%0d_pulse", e.k), int'(pu[e.k]), e.pu);
      check($sformatf("d%0d_paquetes", e.k), act_pk(e.k), e.pk);
    end
  endtask

  // drive one DUT for a cycle, the others idle
  task automatic drv(input int k, input bit r, input bit s, input bit e,
                     input bit ab, input bit ak);
    rst = '0; start = '0; ena = '0; abort = '0; ack = '0;
    rst[k] = r; start[k] = s; ena[k] = e; abort[k] = ab; ack[k] = ak;
    tick();
  endtask

  int seq6 [5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 3'b111; start = '0; ena = '0; abort = '0; ack = '0;
    tick();
    tick();
    check("rst_sel0", int'(sel0), 0);
    check("rst_outs", int'({oc, li, pu}), 0);

    // 1: one full packet, hold, ack
    drv(0, 0, 1, 0, 0, 0);
    check("t1_ocupado", int'(oc[0]), 1);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0, 0);
    check("t1_pulse", int'(pu[0]), 1);
    check("t1_pkt", int'(pk0), 1);
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    check("t1_listo_hold", int'(li[0]), 1);
    check("t1_pulse_once", int'(pu[0]), 0);
    drv(0, 0, 0, 0, 0, 1);
    check("t1_ack_idle", int'(li[0]), 0);

    // 2: wrong-state inputs and gapped ena
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 0);
    drv(0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 0);
    check("t2_sel3", int'(sel0), 3);
    drv(0, 0, 0, 1, 0, 0);
    check("t2_listo", int'(li[0]), 1);
    drv(0, 0, 0, 1, 1, 0);
    check("t2_pkt", int'(pk0), 2);
    drv(0, 0, 0, 0, 0, 1);

    // 3: abort mid-packet and on the last word
    drv(0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 1, 0);
    check("t3_abort_sel", int'(sel0), 0);
    drv(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 1, 0);
    check("t3_abort_last", int'({pu[0], oc[0], li[0]}), 0);
    check("t3_pkt", int'(pk0), 2);

    // 4: back-to-back packets via ack+start
    drv(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 1, 0, 0, 1);
    check("t4_b2b_oc", int'(oc[0]), 1);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0, 0);
    check("t4_pkt", int'(pk0), 4);

    // reset mid-packet
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 1, 0, 1, 0, 0);
    check("rst_mid_pkt", int'(pk0), 0);

    // 5: auto-restart, 3 words per packet
    drv(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drv(1, 0, 0, 1, 0, 0);
    check("t5_pkt", int'(pk1), 3);
    check("t5_oc", int'(oc[1]), 1);

    // 6: one-word packets, 2-bit packet counter wraps
    drv(2, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(2, 0, 0, 1, 0, 0);
      check($sformatf("t6_pkt%0d", i), int'(pk2), seq6[i]);
      drv(2, 0, 1, 0, 0, 1);
    end
    drv(2, 1, 0, 1, 0, 0);
    check("t6_rst", int'({sel2, oc[2], li[2], pu[2], pk2}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
